// File: rtl/prbs31_pkg.sv
// Shared definitions for the PRBS31 (x^31 + x^28 + 1) byte-parallel generator/checker.
package prbs31_pkg;

  localparam int unsigned HIST_W     = 31;
  localparam int unsigned TAP_A      = 30;
  localparam int unsigned TAP_B      = 27;
  localparam int unsigned FILL_BYTES = 4;
  localparam int unsigned FILL_W     = 3;

  typedef enum logic [0:0] {
    SEARCH = 1'b0,
    LOCKED = 1'b1
  } state_t;

  // Number of set bits in a byte (0..8).
  function automatic logic [3:0] popcount8(input logic [7:0] v);
    logic [3:0] n;
    n = '0;
    for (int i = 0; i < 8; i++) begin
      n = n + 4'(v[i]);
    end
    return n;
  endfunction

endpackage

// File: rtl/prbs31_next8.sv
// Advances a PRBS31 history by eight bits; the first generated bit lands in pred[7].
module prbs31_next8
  import prbs31_pkg::*;
(
  input  logic [HIST_W-1:0] h,
  output logic [7:0]        pred,
  output logic [HIST_W-1:0] h_next
);

  logic [HIST_W-1:0] s;

  always_comb begin
    s    = h;
    pred = '0;
    for (int i = 0; i < 8; i++) begin
      pred[7-i] = s[TAP_A] ^ s[TAP_B];
      s         = {s[HIST_W-2:0], pred[7-i]};
    end
    h_next = s;
  end

endmodule

// File: rtl/prbs31_checker.sv
// Self-synchronising PRBS31 byte checker: searches for lock, then free-runs its predictor
// and accumulates a saturating bit-error count.
module prbs31_checker
  import prbs31_pkg::*;
#(
  parameter int unsigned LOCK_N   = 16,
  parameter int unsigned UNLOCK_N = 4,
  parameter int unsigned CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [7:0]       din,
  input  logic             din_valid,
  input  logic             clear,
  output logic             locked,
  output logic             err_byte,
  output logic [CNT_W-1:0] err_cnt
);

  localparam int unsigned MATCH_W = $clog2(LOCK_N + 1);
  localparam int unsigned BAD_W   = $clog2(UNLOCK_N + 1);

  state_t              state, state_d;
  logic [HIST_W-1:0]   h, h_d, h_next;
  logic [FILL_W-1:0]   fill, fill_d;
  logic [MATCH_W-1:0]  match_cnt, match_d;
  logic [BAD_W-1:0]    bad_cnt, bad_d;
  logic [CNT_W-1:0]    cnt_d;
  logic                err_byte_d;
  logic [7:0]          pred;
  logic [3:0]          e;
  logic [CNT_W:0]      sum;

  prbs31_next8 u_next8 (
    .h      (h),
    .pred   (pred),
    .h_next (h_next)
  );

  assign e      = popcount8(din ^ pred);
  assign sum    = {1'b0, err_cnt} + (CNT_W + 1)'(e);
  assign locked = (state == LOCKED);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= SEARCH;
    else        state <= state_d;
  end

  // Next state, history, counters and error accumulation.
  always_comb begin
    state_d    = state;
    h_d        = h;
    fill_d     = fill;
    match_d    = match_cnt;
    bad_d      = bad_cnt;
    cnt_d      = err_cnt;
    err_byte_d = 1'b0;
    if (din_valid) begin
      case (state)
        SEARCH: begin
          h_d = {h[HIST_W-9:0], din};
          if (fill < FILL_W'(FILL_BYTES)) begin
            fill_d = fill + FILL_W'(1);
          end else if ((din == pred) && (h != '0)) begin
            match_d = match_cnt + MATCH_W'(1);
            if (match_d == MATCH_W'(LOCK_N)) state_d = LOCKED;
          end else begin
            match_d = '0;
          end
        end
        LOCKED: begin
          // Feed back the prediction so a corrupted byte cannot poison the history.
          h_d = h_next;
          if (e != '0) begin
            err_byte_d = 1'b1;
            cnt_d      = sum[CNT_W] ? '1 : sum[CNT_W-1:0];
            bad_d      = bad_cnt + BAD_W'(1);
            if (bad_d == BAD_W'(UNLOCK_N)) begin
              state_d = SEARCH;
              fill_d  = '0;
              match_d = '0;
              bad_d   = '0;
            end
          end else begin
            bad_d = '0;
          end
        end
        default: state_d = SEARCH;
      endcase
    end
    if (clear) cnt_d = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h         <= '0;
      fill      <= '0;
      match_cnt <= '0;
      bad_cnt   <= '0;
      err_cnt   <= '0;
      err_byte  <= 1'b0;
    end else begin
      h         <= h_d;
      fill      <= fill_d;
      match_cnt <= match_d;
      bad_cnt   <= bad_d;
      err_cnt   <= cnt_d;
      err_byte  <= err_byte_d;
    end
  end

endmodule

// File: doc/prbs31_checker.md
# prbs31_checker

Receive-side companion to the team's PRBS31 byte-parallel generator. Accepts one PRBS31 (x^31 + x^28 + 1) byte per valid cycle and self-synchronises to the stream. Once locked, it free-runs its own predictor, compares against incoming bytes and counts bit errors. It sits behind the Tiny Tapeout top wrapper:
- `ui_in` drives `din`.
- `uio_in[0]` drives `din_valid`; `uio_in[1]` drives `clear`.
- `uo_out` shows `err_cnt[7:0]`.

## Interface
- `LOCK_N`, default 16: consecutive matching bytes required to enter LOCKED.
- `UNLOCK_N`, default 4: consecutive erroneous bytes that force a return to SEARCH.
- `CNT_W`, default 16: width of the bit-error counter.
- `clk`  in  1  clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `din`  in  8  received byte; `din[7]` is the earliest bit in time.
- `din_valid`  in  1  `din` is sampled on rising `clk` when high.
- `clear`  in  1  synchronous clear of `err_cnt`.
- `locked`  out  1  high while in LOCKED.
- `err_byte`  out  1  one-cycle pulse: the last sampled byte had ≥1 bit error while LOCKED.
- `err_cnt`  out  `CNT_W`  saturating count of bit errors accumulated in LOCKED.

## Operation
- **Sequence:** s[n] = s[n-31] ^ s[n-28].
  - History register `h[30:0]`, `h[0]` = most recent bit; next bit = `h[30] ^ h[27]`.
  - Predicted byte = 8 serial steps from `h`, first generated bit in bit 7.
- **State SEARCH** (reset state). On each valid byte:
  - `h` <= {`h[22:0]`, `din`}.
  - While `fill` < 4: `fill`++ and do no comparison.
  - Otherwise compare `din` with the predicted byte. On a match, `match_cnt`++. On a mismatch, or when `h` is all-zero, set `match_cnt` = 0.
  - When `match_cnt` reaches `LOCK_N`, go to LOCKED.
- **State LOCKED.** On each valid byte:
  - `h` <= {`h[22:0]`, predicted}, so the predictor free-runs and errors do not propagate.
  - `e` = popcount(`din` ^ predicted).
  - If `e` > 0: `err_byte` = 1, `err_cnt` += `e` (saturating at 2^`CNT_W`−1), and `bad_cnt`++.
  - If `e` = 0: `bad_cnt` = 0.
  - When `bad_cnt` reaches `UNLOCK_N`, go to SEARCH with `fill` = 0, `match_cnt` = 0 and `bad_cnt` = 0.
- **`din_valid` low:** no state change except `clear`; `err_byte` is 0.
- **Error counting:** errors are counted only in LOCKED. The bytes that cause unlock are counted.
- **`clear`:**
  - Same cycle as a counted error: `clear` wins, so `err_cnt` = 0 and that byte's errors are discarded.
  - `clear` affects neither `locked` nor the state.
- **Reset:** all registers go to zero and the state goes to SEARCH, including mid-stream.

## Timing
- **Reset values:** `locked` = 0, `err_byte` = 0, `err_cnt` = 0.
- **Registered outputs:** all outputs update on the edge that samples the causing byte and are visible in the following cycle.
- **Lock latency:**
  - From reset, with a clean stream and no gaps: `locked` rises after the edge sampling valid byte 4 + `LOCK_N`, i.e. byte 20 at defaults.
  - Gaps in `din_valid` stretch this time only.
- **Unlock latency:** `locked` falls after the edge sampling the `UNLOCK_N`-th consecutive bad byte.
- **Throughput:** one byte per cycle, no backpressure.

## Structure
- **Package `prbs31_pkg`:**
  - state enum {SEARCH, LOCKED};
  - tap constants 30/27;
  - `popcount8` function.
- **Sub-module `prbs31_next8`:** combinational; maps `h[30:0]` to the predicted byte and next history. It is reusable by the generator.
- **Checker body:** FSM, `fill`/`match_cnt`/`bad_cnt` counters, error accumulator.

## Test plan
- **Clean lock:** clean stream from seed 31'h7FFFFFFF, valid every cycle -> `locked` = 1 after byte 20, `err_cnt` = 0, `err_byte` never high.
- **Single-bit error:** once locked, flip bit 3 of one byte -> `err_byte` pulses once, `err_cnt` = 1, `locked` stays 1, and the following bytes show no further errors.
- **All-zero stream:** 100 all-zero bytes -> `locked` stays 0. Then a clean stream -> `locked` rises after 20 more bytes.
- **Unlock and relock:** once locked, invert 4 consecutive bytes -> `err_cnt` = 32 and `locked` = 0 after the 4th. Then clean bytes -> relock after 20 bytes, and `err_cnt` holds at 32.
- **Saturation and `clear`:** with `CNT_W` = 4, two bytes with all 8 bits flipped, separated by a good byte -> `err_cnt` = 8, then 15 (saturated). Then `clear` -> `err_cnt` = 0. `clear` coincident with an error byte -> `err_cnt` = 0.
- **Valid gaps and reset mid-stream:** random `din_valid` gaps -> lock after 20 valid bytes. Assert `rst_n` low for 1 cycle while locked -> all outputs 0 and `locked` returns 20 valid bytes later.
